// File: rtl/bcd2bin_if.sv
// Conversion handshake between a requester and the bcd2bin converter.
// The requester pulses start with the digits. The converter answers with busy, then a one-cycle done, bin and err.
interface bcd2bin_if;
  logic        start;
  logic [3:0]  bcd0;
  logic [3:0]  bcd1;
  logic [3:0]  bcd2;
  logic [3:0]  bcd3;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, bcd0, bcd1, bcd2, bcd3,
    input  bin, busy, done, err
  );

  modport slave (
    input  start, bcd0, bcd1, bcd2, bcd3,
    output bin, busy, done, err
  );
endinterface

// File: rtl/bcd2bin.sv
// Four-digit BCD to 14-bit binary converter using 16 reverse double-dabble iterations.
// Optional invalid-digit check: define BCD2BIN_DIGIT_CHECK_EN.
module bcd2bin (
  input  logic              clk,
  input  logic              rst_n,
  bcd2bin_if.slave          bus,
  output logic [1:0]        dbg_state
);

  // Handshake: start is taken only in IDLE and the digits are captured on that same edge.
  // busy covers the accepting edge through the edge that leaves DONE.
  // done pulses for one cycle with bin and err valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] bin_q, bin_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] work_step;
  logic        digit_bad;

  // One iteration: shift right, then pull each upper BCD nibble back down by 3 if it reached 8.
  always_comb begin
    work_step = work_q >> 1;
    for (int i = 0; i < 4; i++) begin
      if (work_step[16 + 4*i + 3])
        work_step[16 + 4*i +: 4] = work_step[16 + 4*i +: 4] - 4'd3;
    end
  end

`ifdef BCD2BIN_DIGIT_CHECK_EN
  assign digit_bad = (bus.bcd0 > 4'd9) || (bus.bcd1 > 4'd9) ||
                     (bus.bcd2 > 4'd9) || (bus.bcd3 > 4'd9);
`else
  assign digit_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d  = {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0, 16'h0000};
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          err_d   = digit_bad;
          state_d = CONV;
        end
      end
      CONV: begin
        work_d = work_step;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          bin_d   = err_q ? 14'd0 : work_step[13:0];
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= 32'd0;
      cnt_q   <= 4'd0;
      bin_q   <= 14'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.bin  = bin_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd2bin.sv
// Directed self-checking bench for bcd2bin.
// Expected values are hand-computed decimal results of the applied digits.
module tb_bcd2bin;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         errors;
  int         checks;

  bcd2bin_if bus ();

  bcd2bin dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver: one start pulse, then scrambled digits to prove they were captured at accept.
  task automatic run_conv(input logic [3:0] d3, d2, d1, d0,
                          output int lat, output int b, output int e,
                          output int busy_at_done, output int done_next,
                          output int busy_next);
    @(negedge clk);
    bus.bcd3 = d3; bus.bcd2 = d2; bus.bcd1 = d1; bus.bcd0 = d0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bcd3 = 4'($urandom_range(0, 15));
    bus.bcd2 = 4'($urandom_range(0, 15));
    bus.bcd1 = 4'($urandom_range(0, 15));
    bus.bcd0 = 4'($urandom_range(0, 15));
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    b = int'(bus.bin);
    e = int'(bus.err);
    busy_at_done = int'(bus.busy);
    @(negedge clk);
    done_next = int'(bus.done);
    busy_next = int'(bus.busy);
  endtask

  // Scoreboard: expected results in issue order, popped as each conversion finishes.
  logic [13:0] exp_q[$];

  task automatic conv_and_check(input string tag, input logic [3:0] d3, d2, d1, d0);
    int lat, b, e, bd, dn, bn;
    logic [13:0] exp_bin;
    exp_bin = exp_q.pop_front();
    run_conv(d3, d2, d1, d0, lat, b, e, bd, dn, bn);
    check({tag, " latency"}, lat, 16);
    check({tag, " bin"}, b, int'(exp_bin));
    check({tag, " err"}, e, 0);
    check({tag, " busy at done"}, bd, 1);
    check({tag, " done width"}, dn, 0);
    check({tag, " busy after"}, bn, 0);
  endtask

  initial begin
    int lat, b, e, bd, dn, bn;
    int busy_cnt, done_cnt, cyc;
    int t_done[$];
    errors = 0;
    checks = 0;
    bus.start = 1'b0;
    bus.bcd0 = 4'd0; bus.bcd1 = 4'd0; bus.bcd2 = 4'd0; bus.bcd3 = 4'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check("reset bin", int'(bus.bin), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset err", int'(bus.err), 0);
    check("reset state", int'(dbg_state), 0);
    rst_n = 1'b1;
    @(negedge clk);

    exp_q.push_back(14'd1234);
    exp_q.push_back(14'd9999);
    exp_q.push_back(14'd0);
    exp_q.push_back(14'd1);
    conv_and_check("c1234", 4'd1, 4'd2, 4'd3, 4'd4);
    conv_and_check("c9999", 4'd9, 4'd9, 4'd9, 4'd9);
    conv_and_check("c0000", 4'd0, 4'd0, 4'd0, 4'd0);
    conv_and_check("c0001", 4'd0, 4'd0, 4'd0, 4'd1);

    // A second start during the conversion must be ignored.
    @(negedge clk);
    bus.bcd3 = 4'd0; bus.bcd2 = 4'd0; bus.bcd1 = 4'd4; bus.bcd0 = 4'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        check("ign bin", int'(bus.bin), 42);
      end
      if (i == 4) bus.start = 1'b1;
      if (i == 5) bus.start = 1'b0;
      @(negedge clk);
    end
    check("ign busy cycles", busy_cnt, 17);
    check("ign done count", done_cnt, 1);

    // Reset in the middle of a conversion aborts it.
    @(negedge clk);
    bus.bcd3 = 4'd5; bus.bcd2 = 4'd6; bus.bcd1 = 4'd7; bus.bcd0 = 4'd8;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("abort busy before", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort busy", int'(bus.busy), 0);
    check("abort bin", int'(bus.bin), 0);
    check("abort done", int'(bus.done), 0);
    check("abort state", int'(dbg_state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    check("abort no done", done_cnt, 0);
    exp_q.push_back(14'd5678);
    conv_and_check("c5678", 4'd5, 4'd6, 4'd7, 4'd8);

    // start held high gives back-to-back conversions 18 cycles apart.
    @(negedge clk);
    bus.bcd3 = 4'd0; bus.bcd2 = 4'd0; bus.bcd1 = 4'd0; bus.bcd0 = 4'd7;
    bus.start = 1'b1;
    cyc = 0;
    while (t_done.size() < 3 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) begin
        t_done.push_back(cyc);
        check("b2b bin", int'(bus.bin), 7);
      end
    end
    bus.start = 1'b0;
    check("b2b pulses", t_done.size(), 3);
    if (t_done.size() == 3) begin
      check("b2b gap1", t_done[1] - t_done[0], 18);
      check("b2b gap2", t_done[2] - t_done[1], 18);
    end
    repeat (20) @(negedge clk);

`ifdef BCD2BIN_DIGIT_CHECK_EN
    run_conv(4'd0, 4'd0, 4'hA, 4'd5, lat, b, e, bd, dn, bn);
    check("bad latency", lat, 16);
    check("bad err", e, 1);
    check("bad bin", b, 0);
    run_conv(4'd0, 4'd0, 4'd1, 4'd5, lat, b, e, bd, dn, bn);
    check("after bad err", e, 0);
    check("after bad bin", b, 15);
`else
    run_conv(4'd0, 4'd0, 4'hA, 4'd5, lat, b, e, bd, dn, bn);
    check("nochk latency", lat, 16);
    check("nochk err", e, 0);
    exp_q.push_back(14'd15);
    conv_and_check("c0015", 4'd0, 4'd0, 4'd1, 4'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd2bin.md
BCD2BIN -- requirements
Module: bcd2bin

Interface
REQ-001 Parameters: none; width fixed at four 8421 BCD digits in and 14-bit binary out.
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  conversion request, sampled on the rising edge.
REQ-005 bcd0  input  4  LSB digit (units).
REQ-006 bcd1  input  4  tens digit.
REQ-007 bcd2  input  4  hundreds digit.
REQ-008 bcd3  input  4  MSB digit (thousands).
REQ-009 bin  output  14  binary result, range 0..9999, registered.
REQ-010 busy  output  1  high from the accepting edge until the conversion ends.
REQ-011 done  output  1  one-cycle pulse when bin is valid.
REQ-012 err  output  1  invalid-digit flag, valid with done.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CONV and DONE.
REQ-014 IDLE with start=1 at an edge SHALL load a 32-bit work register.
- Upper 16 bits = {bcd3,bcd2,bcd1,bcd0}; lower 16 bits = 0.
- Iteration counter cleared; busy set; state -> CONV.
REQ-015 Each CONV edge SHALL perform one reverse double-dabble iteration:
- Logical right shift of the whole 32-bit work register by 1.
- Then, for each of the four upper nibbles, subtract 3 if the shifted nibble >= 8.
REQ-016 On the 16th CONV iteration, bin SHALL be loaded with the lower 14 bits of the result, and state -> DONE.
REQ-017 In DONE, done=1 for exactly one cycle; busy falls on the edge leaving DONE; the next state is IDLE.
- Latency: done is high in the cycle after the 16th edge following the start-accepting edge.
REQ-018 start SHALL be ignored while busy=1 or in DONE; no queuing.
REQ-019 BCD inputs SHALL be sampled only at the accepting edge; later input changes do not affect the result.
REQ-020 bin SHALL hold its value until the next DONE entry.
REQ-021 start held high continuously SHALL yield back-to-back conversions, with one IDLE cycle between done and the next accept.
REQ-022 Subtractions SHALL be 4-bit modulo; no carry between nibbles.

Reset
REQ-023 rst_n=0 SHALL asynchronously force:
- state IDLE;
- bin=0, busy=0, done=0, err=0;
- work register and counter cleared.
REQ-024 Reset during CONV SHALL abort the conversion with no done pulse; operation resumes at the first start after rst_n=1.

Configuration
REQ-025 Macro BCD2BIN_DIGIT_CHECK_EN controls the invalid-digit check.
REQ-026 Defined:
- Any input digit > 9 at the accepting edge latches an error flag.
- At DONE, err=1 and bin=0 instead of the computed value.
- err is cleared at the next accept or by reset.
REQ-027 Undefined:
- err is tied 0.
- No digit check logic exists.
- Invalid digits convert through the same algorithm and produce an unspecified bin.

Verification
REQ-028 digits 1,2,3,4 (bcd3..bcd0), start pulse -> after 16 edges, done=1 for 1 cycle, bin=1234 (0x04D2), err=0.
REQ-029 9,9,9,9 -> bin=9999 (0x270F); 0,0,0,0 -> bin=0; 0,0,0,1 -> bin=1.
REQ-030 start=1 again on edge 5 of a conversion of 0,0,4,2 -> ignored; single done, bin=42; busy high for exactly 17 cycles.
REQ-031 With BCD2BIN_DIGIT_CHECK_EN defined, digits 0,0,0xA,5 -> done with err=1, bin=0; next conversion of 0,0,1,5 -> err=0, bin=15.
REQ-032 rst_n low at CONV iteration 8 of 5,6,7,8 -> busy=0, bin=0 immediately, no done; release and start 5,6,7,8 -> bin=5678.
REQ-033 start held high for 3 conversions of 0,0,0,7 -> three done pulses 18 cycles apart, bin=7 each.
